// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data memory responder: word RAM plus GPIO/timer/compare MMIO block
module dmem_responder #(
    parameter int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] GpioOut,
    output logic        TimerIrq
);

    logic [31:0]      mem [DEPTH];
    logic [31:0]      gpio;
    logic [31:0]      cnt;
    logic [31:0]      cmp;
    logic             match;
    logic [1:0]       ctrl;

    logic             is_mmio;
    logic [2:0]       off;
    logic [IDX_W-1:0] ram_idx;
    logic             wr_ram;
    logic             wr_gpio;
    logic             wr_cnt;
    logic             wr_cmp;
    logic             wr_status;
    logic             wr_ctrl;
    logic             ten;
    logic             ien;
    logic             unused_addr;

    assign is_mmio   = Addr[31];
    assign off       = Addr[4:2];
    assign ram_idx   = Addr[IDX_W+1:2];
    assign wr_ram    = MemWrite && !is_mmio;
    assign wr_gpio   = MemWrite && is_mmio && (off == 3'd0);
    assign wr_cnt    = MemWrite && is_mmio && (off == 3'd1);
    assign wr_cmp    = MemWrite && is_mmio && (off == 3'd2);
    assign wr_status = MemWrite && is_mmio && (off == 3'd3);
    assign wr_ctrl   = MemWrite && is_mmio && (off == 3'd4);
    assign ten       = ctrl[0];
    assign ien       = ctrl[1];

    // Bits above the RAM index and the byte offset are deliberately don't-care.
    assign unused_addr = ^{Addr[30:IDX_W+2], Addr[1:0]};

    assign GpioOut  = gpio;
    assign TimerIrq = match && ien;

    // RAM store; contents survive reset, but a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && wr_ram) begin
            mem[ram_idx] <= WriteData;
        end
    end

    // GPIO, compare and control registers written by the core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio <= '0;
            cmp  <= '0;
            ctrl <= '0;
        end else begin
            if (wr_gpio) gpio <= WriteData;
            if (wr_cmp)  cmp  <= WriteData;
            if (wr_ctrl) ctrl <= WriteData[1:0];
        end
    end

    // Free-running timer: a core write takes precedence over the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (wr_cnt) begin
            cnt <= WriteData;
        end else if (ten) begin
            cnt <= cnt + 32'd1;
        end
    end

    // Sticky match flag on pre-edge CNT==CMP; a set beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match <= 1'b0;
        end else if (ten && (cnt == cmp)) begin
            match <= 1'b1;
        end else if (wr_status && WriteData[0]) begin
            match <= 1'b0;
        end
    end

    // Zero-latency load mux; a same-cycle store is not yet visible here.
    always_comb begin
        ReadData = '0;
        if (!is_mmio) begin
            ReadData = mem[ram_idx];
        end else begin
            case (off)
                3'd0:    ReadData = gpio;
                3'd1:    ReadData = cnt;
                3'd2:    ReadData = cmp;
                3'd3:    ReadData = {31'd0, match};
                3'd4:    ReadData = {30'd0, ctrl};
                default: ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam logic [31:0] A_GPIO = 32'h8000_0000;
    localparam logic [31:0] A_CNT  = 32'h8000_0004;
    localparam logic [31:0] A_CMP  = 32'h8000_0008;
    localparam logic [31:0] A_STAT = 32'h8000_000C;
    localparam logic [31:0] A_CTRL = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] GpioOut;
    logic        TimerIrq;

    int n_cmp = 0;
    int n_err = 0;

    dmem_responder #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .Addr(Addr),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .GpioOut(GpioOut),
        .TimerIrq(TimerIrq)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        MemWrite  = we;
        Addr      = a;
        WriteData = d;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, a, d);
        tick(1);
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        drive(1'b0, a, 32'h0);
        d = ReadData;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick(2);
        n_cmp++; if (GpioOut !== 32'h0) begin n_err++; $display("FAIL rst_gpio got %h exp %h", GpioOut, 32'h0); end
        n_cmp++; if (TimerIrq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b exp 0", TimerIrq); end
        reset = 1'b0;
        tick(1);
        rd(A_CNT, v);  n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_cnt got %h exp 0", v); end
        rd(A_CMP, v);  n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_cmp got %h exp 0", v); end
        rd(A_STAT, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_stat got %h exp 0", v); end
        rd(A_CTRL, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_ctrl got %h exp 0", v); end
    endtask

    task automatic test_ram;
        logic [31:0] model [int];
        logic [31:0] v, a, d, ra;
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, v); n_cmp++; if (v !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_basic got %h exp deadbeef", v); end
        rd(32'h10 + 32'(4 * DEPTH), v); n_cmp++; if (v !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_alias got %h exp deadbeef", v); end
        rd(32'h13, v); n_cmp++; if (v !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_byteoff got %h exp deadbeef", v); end
        drive(1'b1, 32'h10, 32'h1234_5678);
        n_cmp++; if (ReadData !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_rdw_old got %h exp deadbeef", ReadData); end
        tick(1);
        MemWrite = 1'b0;
        rd(32'h10, v); n_cmp++; if (v !== 32'h1234_5678) begin n_err++; $display("FAIL ram_rdw_new got %h exp 12345678", v); end
        model[4] = 32'h1234_5678;
        for (int i = 0; i < 40; i++) begin
            a = $urandom() & 32'h7FFF_FFFF;
            d = $urandom();
            wr(a, d);
            model[int'((a >> 2) % DEPTH)] = d;
        end
        foreach (model[k]) begin
            ra = (32'(k) << 2) + 32'(4 * DEPTH) * 32'($urandom_range(0, 1000)) + 32'($urandom_range(0, 3));
            rd(ra, v);
            n_cmp++; if (v !== model[k]) begin n_err++; $display("FAIL ram_rand idx %0d addr %h got %h exp %h", k, ra, v, model[k]); end
        end
    endtask

    task automatic test_timer;
        logic [31:0] v, s;
        int k;
        wr(A_CTRL, 32'd1);
        wr(A_CNT, 32'hFFFF_FFFE);
        rd(A_CNT, v); n_cmp++; if (v !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL tmr_load got %h exp fffffffe", v); end
        tick(1);
        rd(A_CNT, v); n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL tmr_inc got %h exp ffffffff", v); end
        tick(1);
        rd(A_CNT, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL tmr_wrap got %h exp 0", v); end
        wr(A_CTRL, 32'd0);
        rd(A_CNT, v); n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL tmr_stop got %h exp 1", v); end
        tick(3);
        rd(A_CNT, v); n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL tmr_hold got %h exp 1", v); end
        for (int i = 0; i < 4; i++) begin
            s = $urandom();
            k = $urandom_range(1, 9);
            wr(A_CNT, s);
            tick(k);
            rd(A_CNT, v); n_cmp++; if (v !== s) begin n_err++; $display("FAIL tmr_rand_hold got %h exp %h", v, s); end
            wr(A_CTRL, 32'd1);
            s = $urandom();
            wr(A_CNT, s);
            rd(A_CNT, v); n_cmp++; if (v !== s) begin n_err++; $display("FAIL tmr_wr_noinc got %h exp %h", v, s); end
            tick(k);
            rd(A_CNT, v); n_cmp++; if (v !== s + 32'(k)) begin n_err++; $display("FAIL tmr_rand_run got %h exp %h", v, s + 32'(k)); end
            wr(A_CTRL, 32'd0);
        end
    endtask

    task automatic test_match(input logic ien, input logic [31:0] base, input int d);
        logic [31:0] v;
        wr(A_CTRL, 32'd0);
        wr(A_STAT, 32'd1);
        wr(A_CMP, base + 32'(d));
        wr(A_CNT, base);
        wr(A_CTRL, ien ? 32'd3 : 32'd1);
        tick(d);
        rd(A_CNT, v);  n_cmp++; if (v !== base + 32'(d)) begin n_err++; $display("FAIL mt_cnt got %h exp %h", v, base + 32'(d)); end
        rd(A_STAT, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL mt_early got %h exp 0", v); end
        n_cmp++; if (TimerIrq !== 1'b0) begin n_err++; $display("FAIL mt_irq_early got %b exp 0", TimerIrq); end
        tick(1);
        rd(A_STAT, v); n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL mt_set got %h exp 1", v); end
        n_cmp++; if (TimerIrq !== ien) begin n_err++; $display("FAIL mt_irq got %b exp %b", TimerIrq, ien); end
        tick(4);
        wr(A_CMP, base);
        wr(A_STAT, 32'd0);
        rd(A_STAT, v); n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL mt_sticky got %h exp 1", v); end
        n_cmp++; if (TimerIrq !== ien) begin n_err++; $display("FAIL mt_irq_sticky got %b exp %b", TimerIrq, ien); end
        wr(A_STAT, 32'd1);
        rd(A_STAT, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL mt_clear got %h exp 0", v); end
        n_cmp++; if (TimerIrq !== 1'b0) begin n_err++; $display("FAIL mt_irq_clear got %b exp 0", TimerIrq); end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_set_vs_clear;
        logic [31:0] v, base;
        int d;
        for (int i = 0; i < 3; i++) begin
            base = $urandom();
            d = $urandom_range(1, 8);
            wr(A_CTRL, 32'd0);
            wr(A_STAT, 32'd1);
            wr(A_CMP, base + 32'(d));
            wr(A_CNT, base);
            wr(A_CTRL, 32'd1);
            tick(d);
            wr(A_STAT, 32'd1);
            rd(A_STAT, v); n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL svc_setwins got %h exp 1", v); end
            wr(A_STAT, 32'd1);
            rd(A_STAT, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL svc_clear got %h exp 0", v); end
        end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_mmio_decode;
        logic [31:0] v, a, d;
        wr(A_GPIO, 32'hA5A5_A5A5);
        n_cmp++; if (GpioOut !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mmio_gpio got %h exp a5a5a5a5", GpioOut); end
        wr(32'h8000_0018, $urandom());
        n_cmp++; if (GpioOut !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mmio_hole_wr got %h exp a5a5a5a5", GpioOut); end
        rd(32'h8000_0014, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL mmio_hole14 got %h exp 0", v); end
        rd(32'h8000_0018, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL mmio_hole18 got %h exp 0", v); end
        rd(32'h8000_001C, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL mmio_hole1c got %h exp 0", v); end
        rd(32'h8000_0020, v); n_cmp++; if (v !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mmio_alias got %h exp a5a5a5a5", v); end
        wr(A_CTRL, 32'hFFFF_FFFF);
        rd(A_CTRL, v); n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL mmio_ctrl_mask got %h exp 3", v); end
        wr(A_CTRL, 32'd0);
        for (int i = 0; i < 4; i++) begin
            a = 32'h8000_0000 | ($urandom() & 32'h7FFF_FFE0) | 32'($urandom_range(0, 3));
            d = $urandom();
            wr(a, d);
            n_cmp++; if (GpioOut !== d) begin n_err++; $display("FAIL mmio_gpio_rand addr %h got %h exp %h", a, GpioOut, d); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        wr(A_GPIO, 32'h55);
        wr(A_CMP, 32'd0);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'd3);
        tick(3);
        n_cmp++; if (TimerIrq !== 1'b1) begin n_err++; $display("FAIL rmid_pre_irq got %b exp 1", TimerIrq); end
        drive(1'b1, A_GPIO, 32'h77);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++; if (GpioOut !== 32'h0) begin n_err++; $display("FAIL rmid_gpio got %h exp 0", GpioOut); end
        n_cmp++; if (TimerIrq !== 1'b0) begin n_err++; $display("FAIL rmid_irq got %b exp 0", TimerIrq); end
        tick(1);
        MemWrite = 1'b0;
        reset = 1'b0;
        tick(1);
        n_cmp++; if (GpioOut !== 32'h0) begin n_err++; $display("FAIL rmid_drop got %h exp 0", GpioOut); end
        rd(A_CNT, v);  n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rmid_cnt got %h exp 0", v); end
        rd(A_CMP, v);  n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rmid_cmp got %h exp 0", v); end
        rd(A_STAT, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rmid_stat got %h exp 0", v); end
        rd(A_CTRL, v); n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rmid_ctrl got %h exp 0", v); end
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        Addr      = 32'h0;
        WriteData = 32'h0;
        test_reset();
        test_ram();
        test_timer();
        test_match(1'b1, 32'd0, 5);
        test_match(1'b0, 32'd0, 5);
        test_match(1'b1, $urandom(), $urandom_range(2, 12));
        test_match(1'b0, 32'hFFFF_FFFD, 6);
        test_set_vs_clear();
        test_mmio_decode();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
